// File: rtl/demux_striping_n.sv
// Round-robin demux: stripes valid input words across LANES output lanes, one word per lane.
// Define STRIPE_REALIGN_EN to restart at lane 0 after every idle cycle and drop partial stripes.
module demux_striping_n #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LANES      = 4,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          valid_in,
    output logic [LANES*DATA_WIDTH-1:0]   data_out,
    output logic [LANES-1:0]              valid_out,
    output logic [$clog2(LANES)-1:0]      lane_ptr,
    output logic                          stripe_done,
    output logic [CNT_WIDTH-1:0]          stripe_count
);

    localparam int unsigned PTR_W = $clog2(LANES);
    localparam int unsigned BUS_W = LANES * DATA_WIDTH;
    localparam logic [PTR_W-1:0] LAST_LANE = PTR_W'(LANES - 1);

    logic [BUS_W-1:0]     data_q,  data_d;
    logic [LANES-1:0]     valid_q, valid_d;
    logic [PTR_W-1:0]     ptr_q,   ptr_d;
    logic                 done_q,  done_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

    // Next state: write the pointed lane on a valid word; valid/done are single-cycle.
    always_comb begin
        data_d  = data_q;
        valid_d = '0;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (valid_in && (ptr_q == PTR_W'(k))) begin
                data_d[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
                valid_d[k]                         = 1'b1;
            end
        end
        if (valid_in) begin
            // LANES is a power of two, so the natural overflow is the wrap to lane 0.
            ptr_d = ptr_q + PTR_W'(1);
            if (ptr_q == LAST_LANE) begin
                done_d = 1'b1;
                cnt_d  = cnt_q + CNT_WIDTH'(1);
            end
        end else begin
`ifdef STRIPE_REALIGN_EN
            ptr_d = '0;
`else
            ptr_d = ptr_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_q  <= '0;
            valid_q <= '0;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign data_out     = data_q;
    assign valid_out    = valid_q;
    assign lane_ptr     = ptr_q;
    assign stripe_done  = done_q;
    assign stripe_count = cnt_q;

endmodule

// File: tb/tb_demux_striping_n.sv
// Directed self-checking bench for demux_striping_n (DATA_WIDTH=32, LANES=4); follows STRIPE_REALIGN_EN.
module tb_demux_striping_n;

    logic         clk;
    logic         reset_L;
    logic [31:0]  data_in;
    logic         valid_in;
    logic [127:0] data_out;
    logic [3:0]   valid_out;
    logic [1:0]   lane_ptr;
    logic         stripe_done;
    logic [7:0]   stripe_count;

    logic [127:0] b_data_out;
    logic [3:0]   b_valid_out;
    logic [1:0]   b_lane_ptr;
    logic         b_stripe_done;
    logic [1:0]   b_stripe_count;

    int checks;
    int failures;

`ifdef STRIPE_REALIGN_EN
    localparam bit REALIGN = 1'b1;
`else
    localparam bit REALIGN = 1'b0;
`endif

    demux_striping_n #(.DATA_WIDTH(32), .LANES(4), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .data_out(data_out), .valid_out(valid_out), .lane_ptr(lane_ptr),
        .stripe_done(stripe_done), .stripe_count(stripe_count)
    );

    demux_striping_n #(.DATA_WIDTH(32), .LANES(4), .CNT_WIDTH(2)) dut_c2 (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .data_out(b_data_out), .valid_out(b_valid_out), .lane_ptr(b_lane_ptr),
        .stripe_done(b_stripe_done), .stripe_count(b_stripe_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        valid_in = 1'b1;
        data_in  = d;
        step();
    endtask

    task automatic idle(input logic [31:0] d);
        valid_in = 1'b0;
        data_in  = d;
        step();
    endtask

    task automatic do_reset();
        valid_in = 1'b0;
        reset_L  = 1'b0;
        step();
        reset_L  = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"},  data_out, 128'h0);
        check({tag, "_valid"}, 128'(valid_out), 128'h0);
        check({tag, "_ptr"},   128'(lane_ptr), 128'h0);
        check({tag, "_done"},  128'(stripe_done), 128'h0);
        check({tag, "_cnt"},   128'(stripe_count), 128'h0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_L  = 1'b0;
        valid_in = 1'b0;
        data_in  = 32'h0;
        step();
        step();
        check_zero("reset");
        reset_L = 1'b1;

        // One full stripe, first word accepted at the first edge after release.
        send(32'hEEEEEEEE);
        check("s1_valid0", 128'(valid_out), 128'h1);
        check("s1_lane0",  data_out, 128'h0000_0000_0000_0000_0000_0000_EEEE_EEEE);
        check("s1_ptr1",   128'(lane_ptr), 128'h1);
        send(32'hEEEEEEEF);
        check("s1_valid1", 128'(valid_out), 128'h2);
        send(32'hEEEEEEF0);
        check("s1_valid2", 128'(valid_out), 128'h4);
        check("s1_done_early", 128'(stripe_done), 128'h0);
        send(32'hEEEEEEF1);
        check("s1_valid3", 128'(valid_out), 128'h8);
        check("s1_done",   128'(stripe_done), 128'h1);
        check("s1_cnt",    128'(stripe_count), 128'h1);
        check("s1_data",   data_out, 128'hEEEEEEF1_EEEEEEF0_EEEEEEEF_EEEEEEEE);
        idle(32'h0);
        check("s1_done_pulse", 128'(stripe_done), 128'h0);
        check("s1_idle_valid", 128'(valid_out), 128'h0);
        check("s1_idle_ptr",   128'(lane_ptr), 128'h0);

        // Six words, one idle, two words.
        do_reset();
        for (int i = 1; i <= 6; i++) send(32'(i));
        idle(32'hDEADBEEF);
        check("gap_valid", 128'(valid_out), 128'h0);
        check("gap_ptr",   128'(lane_ptr), REALIGN ? 128'h0 : 128'h2);
        send(32'h7);
        check("gap_w7_valid", 128'(valid_out), REALIGN ? 128'h1 : 128'h4);
        send(32'h8);
        check("gap_w8_valid", 128'(valid_out), REALIGN ? 128'h2 : 128'h8);
        check("gap_data", data_out, REALIGN ? 128'h00000004_00000003_00000008_00000007
                                            : 128'h00000008_00000007_00000006_00000005);
        check("gap_cnt",  128'(stripe_count), REALIGN ? 128'h1 : 128'h2);
        check("gap_ptr_end", 128'(lane_ptr), REALIGN ? 128'h2 : 128'h0);
        check("gap_done", 128'(stripe_done), REALIGN ? 128'h0 : 128'h1);

        // Asynchronous reset mid-stripe.
        do_reset();
        send(32'hA);
        send(32'hB);
        valid_in = 1'b0;
        #2;
        reset_L = 1'b0;
        #1;
        check_zero("async");
        #1;
        reset_L = 1'b1;
        send(32'hC);
        check("post_rst_valid", 128'(valid_out), 128'h1);
        check("post_rst_data",  data_out, 128'h0000000C);
        check("post_rst_ptr",   128'(lane_ptr), 128'h1);

        // Idle cycles with toggling data must not disturb state.
        for (int i = 0; i < 3; i++) begin
            idle(i[0] ? 32'h5555_5555 : 32'hAAAA_AAAA);
            check("idle_data",  data_out, 128'h0000000C);
            check("idle_valid", 128'(valid_out), 128'h0);
            check("idle_ptr",   128'(lane_ptr), REALIGN ? 128'h0 : 128'h1);
            check("idle_cnt",   128'(stripe_count), 128'h0);
        end

        // Narrow counter wraps: 1,2,3,0,1 over five stripes.
        do_reset();
        begin
            logic [1:0] exp_cnt [5];
            exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
            exp_cnt[3] = 2'd0; exp_cnt[4] = 2'd1;
            for (int s = 0; s < 5; s++) begin
                for (int w = 0; w < 4; w++) send(32'(s * 4 + w));
                check("c2_cnt",  128'(b_stripe_count), 128'(exp_cnt[s]));
                check("c2_done", 128'(b_stripe_done), 128'h1);
            end
        end
        check("c8_cnt", 128'(stripe_count), 128'h5);
        idle(32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_striping_n.md
DEMUX_STRIPING_N -- requirements
Module: demux_striping_n

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: width of each data word.
REQ-002 The block SHALL have parameter LANES, default 4: number of output lanes; power of two, 2..16.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 8: width of the stripe counter.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_L, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port data_in, input, DATA_WIDTH bits: input word.
REQ-007 The block SHALL have port valid_in, input, 1 bit: data_in is valid this cycle.
REQ-008 The block SHALL have port data_out, output, LANES*DATA_WIDTH bits: lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port valid_out, output, LANES bits: bit k is the valid of lane k.
REQ-010 The block SHALL have port lane_ptr, output, log2(LANES) bits: lane that receives the next valid word.
REQ-011 The block SHALL have port stripe_done, output, 1 bit: one-cycle pulse when a stripe completes.
REQ-012 The block SHALL have port stripe_count, output, CNT_WIDTH bits: number of completed stripes, modulo 2^CNT_WIDTH.

Function
REQ-013 The block SHALL distribute valid words round-robin: with valid_in=1 and lane_ptr=k at edge t, lane k data is set to data_in and valid_out is set to one-hot bit k after edge t (latency 1 cycle).
REQ-014 On every edge the block SHALL set to 0 each valid_out bit that is not written that cycle, so valid_out is always one-hot or zero.
REQ-015 Lanes not written SHALL hold their previous data_out value.
REQ-016 lane_ptr SHALL advance by 1 on each valid word and wrap from LANES-1 to 0.
REQ-017 lane_ptr SHALL hold when valid_in=0, except as given in REQ-024.
REQ-018 When a word is written to lane LANES-1, the block SHALL, at the same edge, set stripe_done=1 for one cycle and increment stripe_count.
REQ-019 stripe_count SHALL wrap from 2^CNT_WIDTH-1 to 0 with no saturation and no error flag.
REQ-020 Back-to-back valid words SHALL be accepted every cycle with no bubbles; the block has no backpressure.
REQ-021 data_in SHALL be ignored, and no state SHALL change other than per REQ-014 and REQ-024, when valid_in=0.

Reset
REQ-022 While reset_L=0, the block SHALL force all outputs to zero: data_out=0, valid_out=0, lane_ptr=0, stripe_done=0, stripe_count=0.
REQ-023 On reset_L deassertion the block SHALL accept a word at the first rising edge; a reset assertion mid-stripe SHALL discard the partial stripe and restart at lane 0.

Configuration
REQ-024 With macro STRIPE_REALIGN_EN defined, the block SHALL force lane_ptr to 0 at any edge where valid_in=0, so each burst starts at lane 0, and SHALL discard a partial stripe without a stripe_done pulse or count increment.
REQ-025 With STRIPE_REALIGN_EN undefined, lane_ptr SHALL hold across idle cycles and a burst SHALL continue the partial stripe.

Verification (DATA_WIDTH=32, LANES=4)
REQ-026 The bench SHALL cover reset then data_in 0xEEEEEEEE..0xEEEEEEF1 on 4 consecutive cycles: lanes 0..3 receive them in order, valid_out=0001,0010,0100,1000, stripe_done pulses with the 4th, stripe_count=1.
REQ-027 The bench SHALL cover 6 valid words, 1 idle cycle, then 2 valid words with realign off: words 7 and 8 land in lanes 2 and 3, stripe_count=2.
REQ-028 The bench SHALL cover the same stimulus as REQ-027 with STRIPE_REALIGN_EN on: words 7 and 8 land in lanes 0 and 1, stripe_count=1, lane_ptr=2.
REQ-029 The bench SHALL cover reset_L pulsed low after 2 valid words: all outputs read 0 asynchronously, and the next word goes to lane 0.
REQ-030 The bench SHALL cover CNT_WIDTH=2 with 20 words: stripe_count reads 1,2,3,0,1 after stripes 1..5.
REQ-031 The bench SHALL cover valid_in=0 with data_in toggling: data_out unchanged, valid_out=0, lane_ptr held.
